// File: rtl/bus_interface_ack_pkg.sv
// -----------------------------------------------------------------------------
// bus_interface_ack_pkg
// Shared constants and types for the Xosera host-bus front end.
//   CS_ENABLED / CS_DISABLED : levels of the active-low chip select
//   RnW_READ / RnW_WRITE     : levels of the read/not-write line
//   DTACK_ACK / DTACK_NAK    : levels of the active-low DTACK output
//   bus_state_t              : access sequencer states
// -----------------------------------------------------------------------------
package bus_interface_ack_pkg;

    localparam logic CS_ENABLED  = 1'b0;
    localparam logic CS_DISABLED = 1'b1;

    localparam logic RnW_WRITE   = 1'b0;
    localparam logic RnW_READ    = 1'b1;

    localparam logic DTACK_ACK   = 1'b0;
    localparam logic DTACK_NAK   = 1'b1;

    // IDLE: waiting for a CS falling edge
    // WAIT: strobe issued, waiting for ack_i (or timeout)
    // DONE: DTACK asserted until the bus releases CS
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } bus_state_t;

endpackage

// File: rtl/bus_interface_ack_sync.sv
// -----------------------------------------------------------------------------
// bus_sync
// Single-bit synchroniser of parametrised depth with asynchronous active-low
// reset and a configurable reset value.
//   STAGES    : flop chain depth, 2..4
//   RESET_VAL : value every stage takes during reset
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_first : output of the first stage (fast, not yet metastability-safe)
//   o_q     : fully synchronised output (last stage)
// -----------------------------------------------------------------------------
module bus_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_first,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the async input through the chain; stage 0 samples the pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_first = r_chain[0];
    assign o_q     = r_chain[STAGES-1];

endmodule

// File: rtl/bus_interface_ack.sv
// -----------------------------------------------------------------------------
// bus_interface_ack
// Host-bus front end: synchronises the asynchronous CPU bus, captures the
// access fields, issues a one-cycle read/write strobe to the register block,
// waits for ack_i (bounded by ACK_TIMEOUT) and then asserts DTACK until the
// CPU releases chip select. Read data is held on bus_data_o while DTACK is on.
// Parameters:
//   DATA_W      : bus data width (8 or 16)
//   REG_W       : register number width
//   SYNC_STAGES : CS synchroniser depth (2..4)
//   ACK_TIMEOUT : max WAIT cycles; 0 means ack is implied after one cycle
// Ports:
//   clk, reset_n_i                   : clock, async active-low reset
//   bus_cs_n_i, bus_rd_nwr_i,
//   bus_reg_num_i, bus_bytesel_i,
//   bus_data_i                       : asynchronous CPU bus inputs
//   bus_data_o, bus_data_oe_o        : read data and pad output enable
//   bus_dtack_n_o                    : DTACK, active low
//   write_strobe_o, read_strobe_o    : one-cycle access strobes
//   reg_num_o, bytesel_o, bytedata_o : captured access fields
//   ack_i, rd_data_i                 : completion and read data from reg block
//   timeout_o                        : one-cycle pulse on access timeout
// -----------------------------------------------------------------------------
module bus_interface_ack
    import bus_interface_ack_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int REG_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              bus_cs_n_i,
    input  logic              bus_rd_nwr_i,
    input  logic [REG_W-1:0]  bus_reg_num_i,
    input  logic              bus_bytesel_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_data_oe_o,
    output logic              bus_dtack_n_o,
    output logic              write_strobe_o,
    output logic              read_strobe_o,
    output logic [REG_W-1:0]  reg_num_o,
    output logic              bytesel_o,
    output logic [DATA_W-1:0] bytedata_o,
    input  logic              ack_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              timeout_o
);

    // A zero timeout still needs a one-bit counter to keep the code legal.
    localparam int CNT_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

    logic              w_cs_first;
    logic              w_cs_sync;
    logic              w_cs_edge;
    logic              r_cs_last;
    logic              r_rd_nwr;
    logic [REG_W-1:0]  r_reg_num;
    logic              r_bytesel;
    logic [DATA_W-1:0] r_data;
    logic              r_is_read;
    logic [CNT_W-1:0]  r_count;
    bus_state_t        r_state;

    // CS chain resets to "enabled" so a CS already low out of reset is not
    // mistaken for a new access; the bus must release CS first.
    bus_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (CS_ENABLED)
    ) u_cs_sync (
        .i_clk   (clk),
        .i_rst_n (reset_n_i),
        .i_d     (bus_cs_n_i),
        .o_first (w_cs_first),
        .o_q     (w_cs_sync)
    );

    // Single input flops for the qualifying bus fields and the CS history bit.
    // These are stable long before the synchronised CS edge reaches the FSM.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cs_last <= CS_ENABLED;
            r_rd_nwr  <= RnW_WRITE;
            r_reg_num <= '0;
            r_bytesel <= 1'b0;
            r_data    <= '0;
        end else begin
            r_cs_last <= w_cs_sync;
            r_rd_nwr  <= bus_rd_nwr_i;
            r_reg_num <= bus_reg_num_i;
            r_bytesel <= bus_bytesel_i;
            r_data    <= bus_data_i;
        end
    end

    assign w_cs_edge = (w_cs_sync == CS_ENABLED) && (r_cs_last == CS_DISABLED);

    // Access sequencer. Strobes and timeout_o default low every cycle so they
    // can only ever be single-cycle pulses. Abort (CS released while waiting)
    // takes priority over ack, and ack takes priority over timeout.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_is_read      <= 1'b0;
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
            timeout_o      <= 1'b0;
            bus_dtack_n_o  <= DTACK_NAK;
            bus_data_oe_o  <= 1'b0;
            bus_data_o     <= '0;
            reg_num_o      <= '0;
            bytesel_o      <= 1'b0;
            bytedata_o     <= '0;
        end else begin
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;
            timeout_o      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_cs_edge) begin
                        reg_num_o      <= r_reg_num;
                        bytesel_o      <= r_bytesel;
                        bytedata_o     <= r_data;
                        r_is_read      <= (r_rd_nwr == RnW_READ);
                        write_strobe_o <= (r_rd_nwr == RnW_WRITE);
                        read_strobe_o  <= (r_rd_nwr == RnW_READ);
                        r_count        <= '0;
                        r_state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_cs_first == CS_DISABLED) begin
                        r_state <= IDLE;
                    end else if ((ACK_TIMEOUT == 0) || ack_i) begin
                        bus_dtack_n_o <= DTACK_ACK;
                        bus_data_oe_o <= r_is_read;
                        if (r_is_read) begin
                            bus_data_o <= rd_data_i;
                        end
                        r_state <= DONE;
                    end else if (r_count == CNT_LAST) begin
                        timeout_o     <= 1'b1;
                        bus_dtack_n_o <= DTACK_ACK;
                        bus_data_oe_o <= r_is_read;
                        if (r_is_read) begin
                            bus_data_o <= '1;
                        end
                        r_state <= DONE;
                    end else if (r_count != {CNT_W{1'b1}}) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (w_cs_first == CS_DISABLED) begin
                        bus_dtack_n_o <= DTACK_NAK;
                        bus_data_oe_o <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interface_ack.sv
// -----------------------------------------------------------------------------
// tb_bus_interface_ack
// Two instances share the bus field lines but have their own CS and ack:
//   dut8  : DATA_W=8,  SYNC_STAGES=2, ACK_TIMEOUT=0
//   dut16 : DATA_W=16, SYNC_STAGES=3, ACK_TIMEOUT=4
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_bus_interface_ack;

    logic        clk = 1'b0;
    logic        resetN;
    logic        cs8;
    logic        cs16;
    logic        rdNwr;
    logic [3:0]  regNum;
    logic        bytesel;
    logic [15:0] busData;
    logic [15:0] rdData;
    logic        ack8;
    logic        ack16Manual;
    logic        ackAuto;
    logic        ack16;

    logic [7:0]  data8O;
    logic        oe8;
    logic        dtack8;
    logic        wrStb8;
    logic        rdStb8;
    logic [3:0]  regNum8;
    logic        bytesel8;
    logic [7:0]  bytedata8;
    logic        timeout8;

    logic [15:0] data16O;
    logic        oe16;
    logic        dtack16;
    logic        wrStb16;
    logic        rdStb16;
    logic [3:0]  regNum16;
    logic        bytesel16;
    logic [15:0] bytedata16;
    logic        timeout16;

    int total = 0;
    int bad   = 0;

    int stb16Cnt  = 0;
    int fall16Cnt = 0;
    int to16Cnt   = 0;
    logic prevDtack16 = 1'b1;

    int stbBase;
    int fallBase;
    int toBase;

    always #5 clk = ~clk;

    // ack for dut16 either follows its strobe or is driven by hand
    assign ack16 = ackAuto ? (wrStb16 | rdStb16) : ack16Manual;

    bus_interface_ack #(
        .DATA_W(8), .REG_W(4), .SYNC_STAGES(2), .ACK_TIMEOUT(0)
    ) dut8 (
        .clk            (clk),
        .reset_n_i      (resetN),
        .bus_cs_n_i     (cs8),
        .bus_rd_nwr_i   (rdNwr),
        .bus_reg_num_i  (regNum),
        .bus_bytesel_i  (bytesel),
        .bus_data_i     (busData[7:0]),
        .bus_data_o     (data8O),
        .bus_data_oe_o  (oe8),
        .bus_dtack_n_o  (dtack8),
        .write_strobe_o (wrStb8),
        .read_strobe_o  (rdStb8),
        .reg_num_o      (regNum8),
        .bytesel_o      (bytesel8),
        .bytedata_o     (bytedata8),
        .ack_i          (ack8),
        .rd_data_i      (rdData[7:0]),
        .timeout_o      (timeout8)
    );

    bus_interface_ack #(
        .DATA_W(16), .REG_W(4), .SYNC_STAGES(3), .ACK_TIMEOUT(4)
    ) dut16 (
        .clk            (clk),
        .reset_n_i      (resetN),
        .bus_cs_n_i     (cs16),
        .bus_rd_nwr_i   (rdNwr),
        .bus_reg_num_i  (regNum),
        .bus_bytesel_i  (bytesel),
        .bus_data_i     (busData),
        .bus_data_o     (data16O),
        .bus_data_oe_o  (oe16),
        .bus_dtack_n_o  (dtack16),
        .write_strobe_o (wrStb16),
        .read_strobe_o  (rdStb16),
        .reg_num_o      (regNum16),
        .bytesel_o      (bytesel16),
        .bytedata_o     (bytedata16),
        .ack_i          (ack16),
        .rd_data_i      (rdData),
        .timeout_o      (timeout16)
    );

    // Event counters for dut16, sampled mid-cycle
    always @(negedge clk) begin
        if (wrStb16 | rdStb16) stb16Cnt <= stb16Cnt + 1;
        if (timeout16) to16Cnt <= to16Cnt + 1;
        if (prevDtack16 && !dtack16) fall16Cnt <= fall16Cnt + 1;
        prevDtack16 <= dtack16;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rnw, input logic [3:0] r,
                                 input logic bs, input logic [15:0] d);
        rdNwr   = rnw;
        regNum  = r;
        bytesel = bs;
        busData = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        resetN      = 1'b0;
        cs8         = 1'b1;
        cs16        = 1'b1;
        rdData      = 16'h0000;
        ack8        = 1'b0;
        ack16Manual = 1'b0;
        ackAuto     = 1'b0;
        applyStimulus(1'b0, 4'h0, 1'b0, 16'h0000);
        step(2);

        // reset values on both instances
        checkOutput("rst_dtack8", 32'(dtack8), 32'd1);
        checkOutput("rst_oe8", 32'(oe8), 32'd0);
        checkOutput("rst_pulses8", 32'({wrStb8, rdStb8, timeout8}), 32'd0);
        checkOutput("rst_fields8", 32'({data8O, regNum8, bytesel8, bytedata8}), 32'd0);
        checkOutput("rst_dtack16", 32'(dtack16), 32'd1);
        checkOutput("rst_data16", 32'(data16O), 32'd0);
        checkOutput("rst_fields16", 32'({regNum16, bytesel16, bytedata16}), 32'd0);
        #3 resetN = 1'b1;
        step(6);

        // dut8 write, ack implied
        applyStimulus(1'b0, 4'h3, 1'b0, 16'h00A5);
        cs8 = 1'b0;
        step(2);
        checkOutput("w_no_early_strobe", 32'(wrStb8), 32'd0);
        step(1);
        checkOutput("w_strobe", 32'(wrStb8), 32'd1);
        checkOutput("w_rdstb", 32'(rdStb8), 32'd0);
        checkOutput("w_regnum", 32'(regNum8), 32'h3);
        checkOutput("w_data", 32'(bytedata8), 32'hA5);
        checkOutput("w_dtack_pre", 32'(dtack8), 32'd1);
        step(1);
        checkOutput("w_strobe_1cyc", 32'(wrStb8), 32'd0);
        checkOutput("w_dtack", 32'(dtack8), 32'd0);
        checkOutput("w_oe_write", 32'(oe8), 32'd0);
        step(1);
        checkOutput("w_dtack_held", 32'(dtack8), 32'd0);
        cs8 = 1'b1;
        step(1);
        checkOutput("w_dtack_cs_sampled", 32'(dtack8), 32'd0);
        step(1);
        checkOutput("w_dtack_release", 32'(dtack8), 32'd1);
        checkOutput("w_fields_held", 32'(regNum8), 32'h3);

        // dut16 read with ack two cycles after the strobe
        applyStimulus(1'b1, 4'h5, 1'b1, 16'h0000);
        cs16 = 1'b0;
        step(3);
        checkOutput("r_no_early_strobe", 32'(rdStb16), 32'd0);
        step(1);
        checkOutput("r_strobe", 32'(rdStb16), 32'd1);
        checkOutput("r_wrstb", 32'(wrStb16), 32'd0);
        checkOutput("r_regnum", 32'(regNum16), 32'h5);
        checkOutput("r_bytesel", 32'(bytesel16), 32'd1);
        step(1);
        checkOutput("r_strobe_1cyc", 32'(rdStb16), 32'd0);
        checkOutput("r_wait1", 32'(dtack16), 32'd1);
        step(1);
        checkOutput("r_wait2", 32'(dtack16), 32'd1);
        ack16Manual = 1'b1;
        rdData      = 16'hBEEF;
        step(1);
        checkOutput("r_dtack", 32'(dtack16), 32'd0);
        checkOutput("r_oe", 32'(oe16), 32'd1);
        checkOutput("r_data", 32'(data16O), 32'hBEEF);
        checkOutput("r_no_timeout", 32'(timeout16), 32'd0);
        ack16Manual = 1'b0;
        rdData      = 16'h0000;
        step(1);
        checkOutput("r_data_held", 32'(data16O), 32'hBEEF);
        cs16 = 1'b1;
        step(1);
        checkOutput("r_oe_held", 32'(oe16), 32'd1);
        step(1);
        checkOutput("r_dtack_release", 32'(dtack16), 32'd1);
        checkOutput("r_oe_release", 32'(oe16), 32'd0);
        step(6);

        // dut16 read timeout after 4 WAIT cycles
        toBase = to16Cnt;
        applyStimulus(1'b1, 4'h7, 1'b0, 16'h0000);
        cs16 = 1'b0;
        step(4);
        checkOutput("t_strobe", 32'(rdStb16), 32'd1);
        step(3);
        checkOutput("t_wait3", 32'(dtack16), 32'd1);
        checkOutput("t_no_early_timeout", 32'(to16Cnt - toBase), 32'd0);
        step(1);
        checkOutput("t_pulse", 32'(timeout16), 32'd1);
        checkOutput("t_dtack", 32'(dtack16), 32'd0);
        checkOutput("t_data_ones", 32'(data16O), 32'hFFFF);
        checkOutput("t_oe", 32'(oe16), 32'd1);
        step(1);
        checkOutput("t_pulse_1cyc", 32'(timeout16), 32'd0);
        checkOutput("t_pulse_count", 32'(to16Cnt - toBase), 32'd1);
        cs16 = 1'b1;
        step(8);

        // dut16 abort: CS released during WAIT, late ack ignored
        toBase   = to16Cnt;
        fallBase = fall16Cnt;
        applyStimulus(1'b1, 4'h9, 1'b0, 16'h0000);
        cs16 = 1'b0;
        step(4);
        checkOutput("a_strobe", 32'(rdStb16), 32'd1);
        cs16 = 1'b1;
        step(2);
        checkOutput("a_idle_dtack", 32'(dtack16), 32'd1);
        ack16Manual = 1'b1;
        rdData      = 16'h1111;
        step(1);
        ack16Manual = 1'b0;
        rdData      = 16'h0000;
        step(5);
        checkOutput("a_no_dtack", 32'(fall16Cnt - fallBase), 32'd0);
        checkOutput("a_no_timeout", 32'(to16Cnt - toBase), 32'd0);
        checkOutput("a_data_kept", 32'(data16O), 32'hFFFF);
        checkOutput("a_oe", 32'(oe16), 32'd0);
        applyStimulus(1'b0, 4'h2, 1'b0, 16'h1234);
        ackAuto = 1'b1;
        cs16    = 1'b0;
        step(4);
        checkOutput("a_next_strobe", 32'(wrStb16), 32'd1);
        checkOutput("a_next_data", 32'(bytedata16), 32'h1234);
        step(1);
        checkOutput("a_next_dtack", 32'(dtack16), 32'd0);
        cs16 = 1'b1;
        step(8);

        // dut16 back-to-back writes, CS high for exactly 2 clocks
        stbBase  = stb16Cnt;
        fallBase = fall16Cnt;
        applyStimulus(1'b0, 4'h8, 1'b0, 16'hAAAA);
        cs16 = 1'b0;
        step(4);
        checkOutput("b_strobe1", 32'(wrStb16), 32'd1);
        checkOutput("b_reg1", 32'(regNum16), 32'h8);
        step(1);
        checkOutput("b_dtack1", 32'(dtack16), 32'd0);
        step(1);
        cs16 = 1'b1;
        step(2);
        checkOutput("b_dtack1_release", 32'(dtack16), 32'd1);
        cs16 = 1'b0;
        applyStimulus(1'b0, 4'h9, 1'b0, 16'h5555);
        step(3);
        checkOutput("b_gap", 32'(wrStb16), 32'd0);
        step(1);
        checkOutput("b_strobe2", 32'(wrStb16), 32'd1);
        checkOutput("b_reg2", 32'(regNum16), 32'h9);
        checkOutput("b_data2", 32'(bytedata16), 32'h5555);
        step(1);
        checkOutput("b_strobe2_1cyc", 32'(wrStb16), 32'd0);
        checkOutput("b_dtack2", 32'(dtack16), 32'd0);
        step(1);
        checkOutput("b_strobe_count", 32'(stb16Cnt - stbBase), 32'd2);
        checkOutput("b_dtack_count", 32'(fall16Cnt - fallBase), 32'd2);
        cs16 = 1'b1;
        step(3);
        ackAuto = 1'b0;

        // dut8 read, then async reset while in DONE
        applyStimulus(1'b1, 4'h1, 1'b0, 16'h0000);
        rdData = 16'h003C;
        cs8    = 1'b0;
        step(3);
        checkOutput("x_strobe", 32'(rdStb8), 32'd1);
        step(1);
        checkOutput("x_dtack", 32'(dtack8), 32'd0);
        checkOutput("x_oe", 32'(oe8), 32'd1);
        checkOutput("x_data", 32'(data8O), 32'h3C);
        #2 resetN = 1'b0;
        #1;
        checkOutput("x_rst_dtack", 32'(dtack8), 32'd1);
        checkOutput("x_rst_oe", 32'(oe8), 32'd0);
        checkOutput("x_rst_data", 32'(data8O), 32'd0);
        #2 resetN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            checkOutput("x_no_strobe", 32'({wrStb8, rdStb8}), 32'd0);
        end
        cs8 = 1'b1;
        step(5);
        cs8 = 1'b0;
        step(3);
        checkOutput("x_strobe_again", 32'(rdStb8), 32'd1);
        step(1);
        checkOutput("x_dtack_again", 32'(dtack8), 32'd0);
        cs8 = 1'b1;
        step(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
